// File: rtl/ddr3_request_arbiter.sv
// Two-requester arbiter for a DDR3 user-side controller. Read tags are tracked in order to route returns.
// Optional: define ARB_ROUND_ROBIN_EN for round-robin grant; default is fixed priority to A.
module ddr3_request_arbiter #(
  parameter int ADDR_BITWIDTH = 18,
  parameter int DQ_BITWIDTH   = 16,
  parameter int RD_TAG_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          a_req_valid,
  output logic                          a_req_ready,
  input  logic                          a_req_write,
  input  logic [ADDR_BITWIDTH-1:0]      a_req_address,
  input  logic [DQ_BITWIDTH-1:0]        a_req_data,
  input  logic                          b_req_valid,
  output logic                          b_req_ready,
  input  logic                          b_req_write,
  input  logic [ADDR_BITWIDTH-1:0]      b_req_address,
  input  logic [DQ_BITWIDTH-1:0]        b_req_data,
  output logic                          a_rd_valid,
  output logic                          b_rd_valid,
  output logic [DQ_BITWIDTH-1:0]        rd_data,
  output logic                          write_enable,
  output logic                          read_enable,
  output logic [ADDR_BITWIDTH-1:0]      i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]        i_user_data,
  input  logic                          ctrl_ready,
  input  logic                          ctrl_rd_valid,
  input  logic [DQ_BITWIDTH-1:0]        o_user_data,
  output logic [$clog2(RD_TAG_DEPTH):0] rd_outstanding,
  output logic                          rd_underflow
);

  localparam int PTR_W = $clog2(RD_TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                    state, state_nxt;
  logic                      tag_full, a_elig, b_elig;
  logic                      grant_any, grant_b;
  logic                      push, pop;
  logic                      req_write_p0, req_id_p0;
  logic [ADDR_BITWIDTH-1:0]  req_addr_p0;
  logic [DQ_BITWIDTH-1:0]    req_data_p0;
  logic [RD_TAG_DEPTH-1:0]   tag_mem;
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
`ifdef ARB_ROUND_ROBIN_EN
  logic                      last_grant;
`endif

  always_comb begin
    tag_full  = (rd_outstanding == CNT_W'(RD_TAG_DEPTH));
    a_elig    = a_req_valid & (a_req_write | ~tag_full);
    b_elig    = b_req_valid & (b_req_write | ~tag_full);
    grant_any = 1'b0;
    grant_b   = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ctrl_ready && (a_elig || b_elig)) begin
          grant_any = 1'b1;
          state_nxt = ISSUE;
          if (a_elig && b_elig) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_b = ~last_grant;
`else
            grant_b = 1'b0;
`endif
          end else begin
            grant_b = b_elig;
          end
        end
      end
      ISSUE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    push = (state == ISSUE) & ~req_write_p0;
    pop  = ctrl_rd_valid & (rd_outstanding != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant resets to B so that A wins the first contended grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       last_grant <= 1'b1;
    else if (grant_any) last_grant <= grant_b;
  end
`endif

  // Stage p0: accepted request latched alongside its ready pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_req_ready  <= 1'b0;
      b_req_ready  <= 1'b0;
      req_write_p0 <= 1'b0;
      req_id_p0    <= 1'b0;
      req_addr_p0  <= '0;
      req_data_p0  <= '0;
    end else begin
      a_req_ready <= grant_any & ~grant_b;
      b_req_ready <= grant_any & grant_b;
      if (grant_any) begin
        req_write_p0 <= grant_b ? b_req_write   : a_req_write;
        req_addr_p0  <= grant_b ? b_req_address : a_req_address;
        req_data_p0  <= grant_b ? b_req_data    : a_req_data;
        req_id_p0    <= grant_b;
      end
    end
  end

  // Stage p1: command pulse to the controller; address/data hold between commands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_enable        <= 1'b0;
      read_enable         <= 1'b0;
      i_user_data_address <= '0;
      i_user_data         <= '0;
    end else begin
      write_enable <= (state == ISSUE) & req_write_p0;
      read_enable  <= (state == ISSUE) & ~req_write_p0;
      if (state == ISSUE) begin
        i_user_data_address <= req_addr_p0;
        i_user_data         <= req_data_p0;
      end
    end
  end

  // Read tag FIFO: requester IDs in issue order, popped on each controller read return
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_mem        <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rd_outstanding <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= req_id_p0;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   rd_outstanding <= rd_outstanding + 1'b1;
        2'b01:   rd_outstanding <= rd_outstanding - 1'b1;
        default: rd_outstanding <= rd_outstanding;
      endcase
    end
  end

  // Stage p1 (return path): routed read data one cycle after the controller return
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rd_valid   <= 1'b0;
      b_rd_valid   <= 1'b0;
      rd_data      <= '0;
      rd_underflow <= 1'b0;
    end else begin
      a_rd_valid <= pop & ~tag_mem[rd_ptr];
      b_rd_valid <= pop & tag_mem[rd_ptr];
      if (pop) rd_data <= o_user_data;
      if (ctrl_rd_valid && (rd_outstanding == '0)) rd_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr3_request_arbiter.sv
// Directed testbench for ddr3_request_arbiter; expectations follow the ARB_ROUND_ROBIN_EN build setting.
module tb_ddr3_request_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          a_req_valid, a_req_ready, a_req_write;
  logic [AW-1:0] a_req_address;
  logic [DW-1:0] a_req_data;
  logic          b_req_valid, b_req_ready, b_req_write;
  logic [AW-1:0] b_req_address;
  logic [DW-1:0] b_req_data;
  logic          a_rd_valid, b_rd_valid;
  logic [DW-1:0] rd_data;
  logic          write_enable, read_enable;
  logic [AW-1:0] i_user_data_address;
  logic [DW-1:0] i_user_data;
  logic          ctrl_ready, ctrl_rd_valid;
  logic [DW-1:0] o_user_data;
  logic [2:0]    rd_outstanding;
  logic          rd_underflow;

  int vectors = 0;
  int miscompares = 0;

  ddr3_request_arbiter #(.ADDR_BITWIDTH(AW), .DQ_BITWIDTH(DW), .RD_TAG_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_write(a_req_write),
    .a_req_address(a_req_address), .a_req_data(a_req_data),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_write(b_req_write),
    .b_req_address(b_req_address), .b_req_data(b_req_data),
    .a_rd_valid(a_rd_valid), .b_rd_valid(b_rd_valid), .rd_data(rd_data),
    .write_enable(write_enable), .read_enable(read_enable),
    .i_user_data_address(i_user_data_address), .i_user_data(i_user_data),
    .ctrl_ready(ctrl_ready), .ctrl_rd_valid(ctrl_rd_valid), .o_user_data(o_user_data),
    .rd_outstanding(rd_outstanding), .rd_underflow(rd_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_req_valid = 0; a_req_write = 0; a_req_address = '0; a_req_data = '0;
    b_req_valid = 0; b_req_write = 0; b_req_address = '0; b_req_data = '0;
    ctrl_ready = 1; ctrl_rd_valid = 0; o_user_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    #2;
    vectors++;
    if ({a_req_ready, b_req_ready, a_rd_valid, b_rd_valid, write_enable, read_enable, rd_underflow} !== 7'b0) begin
      miscompares++; $display("FAIL reset_flags act=%b exp=0000000",
        {a_req_ready, b_req_ready, a_rd_valid, b_rd_valid, write_enable, read_enable, rd_underflow});
    end
    vectors++;
    if (rd_outstanding !== 3'd0 || rd_data !== 16'h0 || i_user_data !== 16'h0 || i_user_data_address !== 18'h0) begin
      miscompares++; $display("FAIL reset_data act=%0h/%0h/%0h/%0h exp=0/0/0/0",
        rd_outstanding, rd_data, i_user_data, i_user_data_address);
    end
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    a_req_valid = 1; a_req_write = 1; a_req_address = 18'h00010; a_req_data = 16'hBEEF;
    tick();
    vectors++;
    if (a_req_ready !== 1'b1 || write_enable !== 1'b0) begin
      miscompares++; $display("FAIL wr_accept act=ready%b/we%b exp=ready1/we0", a_req_ready, write_enable);
    end
    a_req_valid = 0;
    tick();
    vectors++;
    if (write_enable !== 1'b1 || read_enable !== 1'b0 || a_req_ready !== 1'b0) begin
      miscompares++; $display("FAIL wr_cmd act=we%b/re%b/rdy%b exp=we1/re0/rdy0", write_enable, read_enable, a_req_ready);
    end
    vectors++;
    if (i_user_data_address !== 18'h00010 || i_user_data !== 16'hBEEF) begin
      miscompares++; $display("FAIL wr_cmd_data act=%0h/%0h exp=10/beef", i_user_data_address, i_user_data);
    end
    tick();
    vectors++;
    if (write_enable !== 1'b0 || i_user_data_address !== 18'h00010 || i_user_data !== 16'hBEEF) begin
      miscompares++; $display("FAIL wr_hold act=we%b/%0h/%0h exp=we0/10/beef", write_enable, i_user_data_address, i_user_data);
    end
  endtask

  task automatic test_arbitration();
    logic exp_b;
    do_reset();
    a_req_valid = 1; a_req_write = 1; a_req_address = 18'h1; a_req_data = 16'hAAAA;
    b_req_valid = 1; b_req_write = 1; b_req_address = 18'h2; b_req_data = 16'hBBBB;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_b = (i % 2) == 1;
`else
      exp_b = 1'b0;
`endif
      tick();
      vectors++;
      if (a_req_ready !== ~exp_b || b_req_ready !== exp_b) begin
        miscompares++; $display("FAIL arb_grant%0d act=a%b/b%b exp=a%b/b%b", i, a_req_ready, b_req_ready, ~exp_b, exp_b);
      end
      tick();
      vectors++;
      if (write_enable !== 1'b1 || i_user_data_address !== (exp_b ? 18'h2 : 18'h1)
          || i_user_data !== (exp_b ? 16'hBBBB : 16'hAAAA)) begin
        miscompares++; $display("FAIL arb_cmd%0d act=we%b/%0h/%0h exp_b=%b", i, write_enable,
          i_user_data_address, i_user_data, exp_b);
      end
    end
    a_req_valid = 0; b_req_valid = 0;
    tick();
    tick();
  endtask

  task automatic test_tag_full();
    do_reset();
    b_req_valid = 1; b_req_write = 0; b_req_address = 18'h40;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (b_req_ready !== 1'b1) begin
        miscompares++; $display("FAIL full_grant%0d act=%b exp=1", i, b_req_ready);
      end
      tick();
      vectors++;
      if (read_enable !== 1'b1 || write_enable !== 1'b0) begin
        miscompares++; $display("FAIL full_rdcmd%0d act=re%b/we%b exp=re1/we0", i, read_enable, write_enable);
      end
    end
    vectors++;
    if (rd_outstanding !== 3'd4) begin
      miscompares++; $display("FAIL full_count act=%0d exp=4", rd_outstanding);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (b_req_ready !== 1'b0 || read_enable !== 1'b0) begin
        miscompares++; $display("FAIL full_hold%0d act=rdy%b/re%b exp=rdy0/re0", i, b_req_ready, read_enable);
      end
    end
    a_req_valid = 1; a_req_write = 1; a_req_address = 18'h55; a_req_data = 16'h1111;
    tick();
    vectors++;
    if (a_req_ready !== 1'b1 || b_req_ready !== 1'b0) begin
      miscompares++; $display("FAIL full_wr_grant act=a%b/b%b exp=a1/b0", a_req_ready, b_req_ready);
    end
    a_req_valid = 0; b_req_valid = 0;
    tick();
    vectors++;
    if (write_enable !== 1'b1 || i_user_data_address !== 18'h55 || rd_outstanding !== 3'd4) begin
      miscompares++; $display("FAIL full_wr_cmd act=we%b/%0h/cnt%0d exp=we1/55/cnt4", write_enable,
        i_user_data_address, rd_outstanding);
    end
  endtask

  task automatic test_read_return();
    do_reset();
    a_req_valid = 1; a_req_write = 0; a_req_address = 18'h20;
    tick();
    a_req_valid = 0;
    tick();
    vectors++;
    if (read_enable !== 1'b1 || i_user_data_address !== 18'h20 || rd_outstanding !== 3'd1) begin
      miscompares++; $display("FAIL rr_issue_a act=re%b/%0h/cnt%0d exp=re1/20/cnt1", read_enable,
        i_user_data_address, rd_outstanding);
    end
    b_req_valid = 1; b_req_write = 0; b_req_address = 18'h30;
    tick();
    b_req_valid = 0;
    ctrl_rd_valid = 1; o_user_data = 16'h1234;
    tick();
    vectors++;
    if (read_enable !== 1'b1 || i_user_data_address !== 18'h30 || rd_outstanding !== 3'd1) begin
      miscompares++; $display("FAIL rr_push_pop act=re%b/%0h/cnt%0d exp=re1/30/cnt1", read_enable,
        i_user_data_address, rd_outstanding);
    end
    vectors++;
    if (a_rd_valid !== 1'b1 || b_rd_valid !== 1'b0 || rd_data !== 16'h1234) begin
      miscompares++; $display("FAIL rr_ret_a act=a%b/b%b/%0h exp=a1/b0/1234", a_rd_valid, b_rd_valid, rd_data);
    end
    o_user_data = 16'h5678;
    tick();
    ctrl_rd_valid = 0;
    vectors++;
    if (a_rd_valid !== 1'b0 || b_rd_valid !== 1'b1 || rd_data !== 16'h5678 || rd_outstanding !== 3'd0) begin
      miscompares++; $display("FAIL rr_ret_b act=a%b/b%b/%0h/cnt%0d exp=a0/b1/5678/cnt0", a_rd_valid, b_rd_valid,
        rd_data, rd_outstanding);
    end
    tick();
    vectors++;
    if (a_rd_valid !== 1'b0 || b_rd_valid !== 1'b0 || rd_underflow !== 1'b0) begin
      miscompares++; $display("FAIL rr_quiet act=a%b/b%b/uf%b exp=a0/b0/uf0", a_rd_valid, b_rd_valid, rd_underflow);
    end
  endtask

  task automatic test_underflow();
    ctrl_rd_valid = 1; o_user_data = 16'hDEAD;
    tick();
    ctrl_rd_valid = 0;
    vectors++;
    if (a_rd_valid !== 1'b0 || b_rd_valid !== 1'b0 || rd_underflow !== 1'b1) begin
      miscompares++; $display("FAIL uf_set act=a%b/b%b/uf%b exp=a0/b0/uf1", a_rd_valid, b_rd_valid, rd_underflow);
    end
    tick();
    tick();
    vectors++;
    if (rd_underflow !== 1'b1 || rd_outstanding !== 3'd0) begin
      miscompares++; $display("FAIL uf_sticky act=uf%b/cnt%0d exp=uf1/cnt0", rd_underflow, rd_outstanding);
    end
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    a_req_valid = 1; a_req_write = 0; a_req_address = 18'h7;
    tick();
    a_req_valid = 0;
    tick();
    a_req_valid = 1; a_req_write = 1; a_req_address = 18'h9; a_req_data = 16'h9999;
    tick();
    vectors++;
    if (a_req_ready !== 1'b1 || rd_outstanding !== 3'd1) begin
      miscompares++; $display("FAIL mid_setup act=rdy%b/cnt%0d exp=rdy1/cnt1", a_req_ready, rd_outstanding);
    end
    a_req_valid = 0;
    reset_n = 0;
    #1;
    vectors++;
    if ({a_req_ready, write_enable, read_enable, a_rd_valid, b_rd_valid} !== 5'b0 || rd_outstanding !== 3'd0
        || i_user_data_address !== 18'h0 || i_user_data !== 16'h0) begin
      miscompares++; $display("FAIL mid_async act=%b/cnt%0d/%0h/%0h exp=0/cnt0/0/0",
        {a_req_ready, write_enable, read_enable, a_rd_valid, b_rd_valid}, rd_outstanding,
        i_user_data_address, i_user_data);
    end
    tick();
    vectors++;
    if (write_enable !== 1'b0 || read_enable !== 1'b0) begin
      miscompares++; $display("FAIL mid_no_cmd act=we%b/re%b exp=we0/re0", write_enable, read_enable);
    end
    #3 reset_n = 1;
    tick();
    vectors++;
    if (write_enable !== 1'b0 || read_enable !== 1'b0 || rd_outstanding !== 3'd0) begin
      miscompares++; $display("FAIL mid_after act=we%b/re%b/cnt%0d exp=we0/re0/cnt0", write_enable, read_enable,
        rd_outstanding);
    end
    b_req_valid = 1; b_req_write = 1; b_req_address = 18'h3; b_req_data = 16'h3333;
    tick();
    vectors++;
    if (b_req_ready !== 1'b1) begin
      miscompares++; $display("FAIL mid_idle act=%b exp=1", b_req_ready);
    end
    b_req_valid = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_arbitration();
    test_tag_full();
    test_read_return();
    test_underflow();
    test_reset_mid_issue();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
